// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_pkg
// Purpose  : Shared opcodes, FSM state encoding and byte-lane helpers for the
//            SPI memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WREN  = 3'd2,
    ST_GAP   = 3'd3,
    ST_WRITE = 3'd4,
    ST_ACK   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // A write lane mask is usable only when it is one nonzero contiguous run.
  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100,
      4'b0111, 4'b1110, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Number of bytes carried by the write frame.
  function automatic logic [2:0] sel_count(input logic [3:0] sel);
    return {2'b00, sel[0]} + {2'b00, sel[1]} + {2'b00, sel[2]} + {2'b00, sel[3]};
  endfunction

  // Index of the lowest enabled lane: the byte offset of the first data byte.
  function automatic logic [1:0] sel_offset(input logic [3:0] sel);
    if (sel[0])      return 2'd0;
    else if (sel[1]) return 2'd1;
    else if (sel[2]) return 2'd2;
    else             return 2'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mem_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_shifter
// Purpose  : SPI mode-3 frame engine. Shifts out up to 64 bits MSB first,
//            shifts in MISO on rising edges, generates SCLK from clk with a
//            CLK_DIV half-period divider. busy doubles as chip-select active.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  nbits,
  input  logic [63:0] frame,
  input  logic        miso,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        done,
  output logic [31:0] rx_word
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          r_active;
  logic          r_sclk;
  logic          r_mosi;
  logic [DW-1:0] r_div;
  logic [6:0]    r_bits;
  logic [63:0]   r_sh;
  logic [31:0]   r_rx;
  logic          w_tick;

  assign w_tick  = r_active && (r_div == DIV_LAST);
  // done fires in the same cycle as the final rising edge is scheduled, so
  // chip-select and the FSM's completion state change on the same clk edge.
  assign done    = w_tick && !r_sclk && (r_bits == 7'd1);
  // Includes the bit being sampled now; complete while done is high.
  assign rx_word = {r_rx[30:0], miso};
  assign busy    = r_active;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;

  // Half-period divider, falling-edge shift-out and rising-edge shift-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b1;
      r_mosi   <= 1'b0;
      r_div    <= '0;
      r_bits   <= '0;
      r_sh     <= '0;
      r_rx     <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_sclk   <= 1'b1;
      r_div    <= '0;
      r_bits   <= nbits;
      r_sh     <= frame;
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (r_sclk) begin
          r_sclk <= 1'b0;
          r_mosi <= r_sh[63];
          r_sh   <= {r_sh[62:0], 1'b0};
        end else begin
          r_sclk <= 1'b1;
          r_rx   <= rx_word;
          r_bits <= r_bits - 7'd1;
          if (r_bits == 7'd1) r_active <= 1'b0;
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_ctrl
// Purpose  : Wishbone-classic slave mapping a bus window onto NUM_CS serial
//            SPI memories (READ 0x03 / WRITE 0x02 / WREN 0x06).
//            Optional one-word read cache when SPI_MEM_RDCACHE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int NUM_CS     = 1,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [29:0]       adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [NUM_CS-1:0] spiCs_o,
  output logic              spiClk_o,
  output logic              spiMosi_o,
  input  logic              spiMiso_i
);

  localparam int AW  = 8 * ADDR_BYTES;
  localparam int WW  = AW - 2;
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int FW  = 8 + AW + 32;
  localparam int GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [6:0]    RD_BITS   = 7'(FW);
  localparam logic [6:0]    WREN_BITS = 7'd8;
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  state_t          r_state, w_next;
  logic [3:0]      r_sel;
  logic [WW-1:0]   r_word;
  logic [31:0]     r_dat;
  logic [CSW-1:0]  r_dev;
  logic [GW-1:0]   r_gap;
  logic [CSW-1:0]  w_dev;
  logic            w_dev_ok;
  logic            w_capture;
  logic            w_hit;
  logic            w_hit_load;
  logic [31:0]     w_cdata;
  logic            w_start;
  logic [6:0]      w_nbits;
  logic [63:0]     w_frame;
  logic            w_busy;
  logic            w_done;
  logic [31:0]     w_rx;
  logic [31:0]     w_rx_le;
  logic            w_unused;

  // Read frame: opcode, word-aligned byte address, 32 dummy clocks for data.
  function automatic logic [63:0] rd_frame(input logic [WW-1:0] word);
    logic [FW-1:0] f;
    f = {OP_READ, word, 2'b00, 32'h0};
    return 64'(f) << (64 - FW);
  endfunction

  // Write frame: opcode, start byte address, enabled bytes lowest lane first.
  function automatic logic [63:0] wr_frame(input logic [WW-1:0] word,
                                           input logic [3:0] sel,
                                           input logic [31:0] dat);
    logic [FW-1:0] f;
    logic [31:0]   d;
    logic [1:0]    lo;
    lo = sel_offset(sel);
    d  = dat >> {lo, 3'b000};
    f  = {OP_WRITE, word, lo, d[7:0], d[15:8], d[23:16], d[31:24]};
    return 64'(f) << (64 - FW);
  endfunction

  generate
    if (NUM_CS > 1) begin : g_multi_cs
      assign w_dev = adr_i[WW +: CSW];
    end else begin : g_single_cs
      assign w_dev = '0;
    end
  endgenerate

  assign w_dev_ok = (int'(w_dev) < NUM_CS);
  // First received byte sits in rx_word[31:24] and belongs in dat_o[7:0].
  assign w_rx_le  = {w_rx[7:0], w_rx[15:8], w_rx[23:16], w_rx[31:24]};
  assign w_unused = ^adr_i;

  spi_mem_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (w_start),
    .nbits   (w_nbits),
    .frame   (w_frame),
    .miso    (spiMiso_i),
    .busy    (w_busy),
    .sclk    (spiClk_o),
    .mosi    (spiMosi_o),
    .done    (w_done),
    .rx_word (w_rx)
  );

  assign spiCs_o = w_busy ? ~(NUM_CS'(1) << r_dev) : '1;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state, frame launch and bus response decode.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_nbits    = '0;
    w_frame    = '0;
    w_capture  = 1'b0;
    w_hit_load = 1'b0;
    ack_o      = 1'b0;
    err_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stb_i) begin
          w_capture = 1'b1;
          if (!w_dev_ok || (we_i && !sel_legal(sel_i))) begin
            w_next = ST_ERR;
          end else if (we_i) begin
            w_next  = ST_WREN;
            w_start = 1'b1;
            w_nbits = WREN_BITS;
            w_frame = {OP_WREN, 56'h0};
          end else if (w_hit) begin
            w_next     = ST_ACK;
            w_hit_load = 1'b1;
          end else begin
            w_next  = ST_READ;
            w_start = 1'b1;
            w_nbits = RD_BITS;
            w_frame = rd_frame(adr_i[WW-1:0]);
          end
        end
      end
      ST_READ:  if (w_done) w_next = ST_ACK;
      ST_WREN:  if (w_done) w_next = ST_GAP;
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_next  = ST_WRITE;
          w_start = 1'b1;
          w_nbits = 7'(8 + AW) + 7'({sel_count(r_sel), 3'b000});
          w_frame = wr_frame(r_word, r_sel, r_dat);
        end
      end
      ST_WRITE: if (w_done) w_next = ST_ACK;
      ST_ACK: begin
        ack_o  = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR: begin
        err_o  = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request fields are frozen when IDLE accepts the strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel  <= '0;
      r_word <= '0;
      r_dat  <= '0;
      r_dev  <= '0;
    end else if (w_capture) begin
      r_sel  <= sel_i;
      r_word <= adr_i[WW-1:0];
      r_dat  <= dat_i;
      r_dev  <= w_dev;
    end
  end

  // Chip-select high time between WREN and WRITE.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != ST_GAP)) r_gap <= '0;
    else                              r_gap <= r_gap + GW'(1);
  end

  // Read data register, held until the next read completes.
  always_ff @(posedge clk_i) begin
    if (rst_i)                           dat_o <= '0;
    else if (r_state == ST_READ && w_done) dat_o <= w_rx_le;
    else if (w_hit_load)                 dat_o <= w_cdata;
  end

`ifdef SPI_MEM_RDCACHE_EN
  logic           r_cvalid;
  logic [CSW-1:0] r_ccs;
  logic [WW-1:0]  r_cword;
  logic [31:0]    r_cdata;
  logic           r_we;

  assign w_hit   = r_cvalid && (r_ccs == w_dev) && (r_cword == adr_i[WW-1:0]);
  assign w_cdata = r_cdata;

  // Fill on read completion; write-through of enabled lanes on write ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cvalid <= 1'b0;
      r_ccs    <= '0;
      r_cword  <= '0;
      r_cdata  <= '0;
      r_we     <= 1'b0;
    end else begin
      if (w_capture) r_we <= we_i;
      if (r_state == ST_READ && w_done) begin
        r_cvalid <= 1'b1;
        r_ccs    <= r_dev;
        r_cword  <= r_word;
        r_cdata  <= w_rx_le;
      end else if (r_state == ST_ACK && r_we && r_cvalid &&
                   r_ccs == r_dev && r_cword == r_word) begin
        for (int i = 0; i < 4; i++) begin
          if (r_sel[i]) r_cdata[8*i +: 8] <= r_dat[8*i +: 8];
        end
      end
    end
  end
`else
  assign w_hit   = 1'b0;
  assign w_cdata = '0;
`endif

endmodule
`default_nettype wire
